scoreboard_regfile: RTL and testbench

Parametrised register file with an integrated write-pending scoreboard, for the next-generation pipelined core. It sits in the decode stage. It supplies NRD source operands, tracks every destination issued but not yet written back, and raises a combinational stall for RAW and WAW hazards. This replaces fixed load-use hazard detection, so multi-cycle units (loads, multiply, divide) can return results at any latency.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/regfile_bank.sv | 54 +++++
 rtl/scoreboard_regfile.sv | 125 ++++++++++++
 tb/tb_scoreboard_regfile.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode-stage types and constants for the scoreboarded register file.
// The macro WB_BYPASS_EN enables same-cycle writeback forwarding.
package cpu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREG_DEF    = 32;
    localparam int AW_DEF      = $clog2(NREG_DEF);
    localparam int STALL_CNT_W = 16;

    localparam int unsigned ZERO_REG = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_bank.sv
// NREG x XLEN register storage: one write port, NRD combinational read ports.
// Register 0 never stores data and always reads as zero.
module regfile_bank
    import cpu_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we_i && (waddr_i != AW'(ZERO_REG))) begin
            mem_d[waddr_i] = wdata_i;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (raddr_i[k*AW +: AW] != AW'(ZERO_REG)) begin
                rdata_o[k*XLEN +: XLEN] = mem_q[raddr_i[k*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Decode-stage register file with write-pending scoreboard and RAW/WAW stall.
// Define WB_BYPASS_EN to forward same-cycle writeback data and clear hazards.
module scoreboard_regfile
    import cpu_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_valid_i,
    input  logic [NRD*AW-1:0]      issue_rs_i,
    input  logic [NRD-1:0]         issue_rs_used_i,
    input  logic [AW-1:0]          issue_rd_i,
    input  logic                   issue_rd_we_i,
    output logic                   issue_stall_o,
    output logic [NRD*XLEN-1:0]    rdata_o,
    input  logic                   wb_valid_i,
    input  logic [AW-1:0]          wb_rd_i,
    input  logic [XLEN-1:0]        wb_data_i,
    output logic [NREG-1:0]        busy_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   err_o
);

    logic [NREG-1:0]        pend_q, pend_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [NRD*XLEN-1:0]    bank_rdata;
    logic [NRD-1:0]         raw;
    logic                   waw;
    logic                   wb_hit;
    logic                   stall;
    logic                   accept;

    regfile_bank #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) u_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wb_valid_i),
        .waddr_i (wb_rd_i),
        .wdata_i (wb_data_i),
        .raddr_i (issue_rs_i),
        .rdata_o (bank_rdata)
    );

    always_comb begin
        wb_hit = wb_valid_i && (wb_rd_i != AW'(ZERO_REG));
        raw    = '0;
        for (int k = 0; k < NRD; k++) begin
            raw[k] = issue_rs_used_i[k]
                   && (issue_rs_i[k*AW +: AW] != AW'(ZERO_REG))
                   && pend_q[issue_rs_i[k*AW +: AW]];
`ifdef WB_BYPASS_EN
            if (wb_hit && (wb_rd_i == issue_rs_i[k*AW +: AW])) begin
                raw[k] = 1'b0;
            end
`endif
        end
        waw = issue_rd_we_i
            && (issue_rd_i != AW'(ZERO_REG))
            && pend_q[issue_rd_i];
`ifdef WB_BYPASS_EN
        if (wb_hit && (wb_rd_i == issue_rd_i)) begin
            waw = 1'b0;
        end
`endif
        stall  = issue_valid_i && ((|raw) || waw);
        accept = issue_valid_i && !stall;
    end

    always_comb begin
        rdata_o = bank_rdata;
`ifdef WB_BYPASS_EN
        for (int k = 0; k < NRD; k++) begin
            if (wb_hit && (wb_rd_i == issue_rs_i[k*AW +: AW])) begin
                rdata_o[k*XLEN +: XLEN] = wb_data_i;
            end
        end
`endif
    end

    // Set after clear: a same-cycle new writer keeps the entry pending.
    always_comb begin
        pend_d = pend_q;
        if (wb_hit) begin
            pend_d[wb_rd_i] = 1'b0;
        end
        if (accept && issue_rd_we_i && (issue_rd_i != AW'(ZERO_REG))) begin
            pend_d[issue_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q || (wb_hit && !pend_q[wb_rd_i]);
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign issue_stall_o = stall;
    assign busy_o        = pend_q;
    assign stall_cnt_o   = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomised and directed scoreboard bench for scoreboard_regfile.
module tb_scoreboard_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        iv;
    logic [9:0]  irs;
    logic [1:0]  iused;
    logic [4:0]  ird;
    logic        iwe;
    logic        stall;
    logic [63:0] rdata;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] busy;
    logic [15:0] cnt;
    logic        err;

    scoreboard_regfile #(
        .XLEN (32),
        .NREG (32),
        .NRD  (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .issue_valid_i   (iv),
        .issue_rs_i      (irs),
        .issue_rs_used_i (iused),
        .issue_rd_i      (ird),
        .issue_rd_we_i   (iwe),
        .issue_stall_o   (stall),
        .rdata_o         (rdata),
        .wb_valid_i      (wv),
        .wb_rd_i         (wrd),
        .wb_data_i       (wd),
        .busy_o          (busy),
        .stall_cnt_o     (cnt),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [63:0] rdata;
        logic [31:0] busy;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerrs   = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_err;
    int          m_cnt;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic bit covered(logic [4:0] a);
        return BYP && wv && (wrd != 0) && (wrd == a);
    endfunction

    function automatic bit m_stall();
        bit h = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] rs = irs[k*5 +: 5];
            if (iused[k] && rs != 0 && m_pend[rs] && !covered(rs)) h = 1'b1;
        end
        if (iwe && ird != 0 && m_pend[ird] && !covered(ird)) h = 1'b1;
        return iv && h;
    endfunction

    function automatic void m_commit();
        bit s;
        bit set;
        if (!rst_n) begin
            m_reset();
            return;
        end
        s   = m_stall();
        set = iv && !s && iwe && (ird != 0);
        if (s && m_cnt < 65535) m_cnt++;
        if (wv && wrd != 0) begin
            m_regs[wrd] = wd;
            if (!m_pend[wrd]) m_err = 1'b1;
            m_pend[wrd] = 1'b0;
        end
        if (set) m_pend[ird] = 1'b1;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.stall = m_stall();
        e.rdata = '0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] rs = irs[k*5 +: 5];
            if (rs == 0)          e.rdata[k*32 +: 32] = '0;
            else if (covered(rs)) e.rdata[k*32 +: 32] = wd;
            else                  e.rdata[k*32 +: 32] = m_regs[rs];
        end
        for (int i = 0; i < 32; i++) e.busy[i] = m_pend[i];
        e.cnt = 16'(m_cnt);
        e.err = m_err;
        exp_q.push_back(e);
    endfunction

    task automatic chk(string n, logic [63:0] got, logic [63:0] want);
        nchecks++;
        if (got !== want) begin
            nerrs++;
            $display("FAIL %s @%0t: got %h expected %h", n, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", 64'(stall), 64'(e.stall));
            chk("rdata", rdata, e.rdata);
            chk("busy", 64'(busy), 64'(e.busy));
            chk("stall_cnt", 64'(cnt), 64'(e.cnt));
            chk("err", 64'(err), 64'(e.err));
        end
    end

    task automatic step(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic we,
                        input logic w, input logic [4:0] wr, input logic [31:0] d);
        @(posedge clk);
        #1;
        m_commit();
        iv    = v;
        irs   = {rs1, rs0};
        iused = used;
        ird   = rd;
        iwe   = we;
        wv    = w;
        wrd   = wr;
        wd    = d;
        push_exp();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_rst(input logic r);
        @(posedge clk);
        #1;
        m_commit();
        rst_n = r;
        if (!r) m_reset();
        push_exp();
    endtask

    task automatic rand_step();
        logic [4:0] wr;
        wr = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) begin
            for (int t = 0; t < 8; t++) begin
                logic [4:0] c = 5'($urandom_range(1, 7));
                if (m_pend[c]) begin
                    wr = c;
                    break;
                end
            end
        end
        step(1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), wr, $urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        iv = 0; irs = 0; iused = 0; ird = 0; iwe = 0;
        wv = 0; wrd = 0; wd = 0;
        m_reset();
        #1;
        push_exp();
        @(negedge clk);
        set_rst(1'b1);

        for (int r = 1; r < 32; r += 2) begin
            step(0, 5'(r), 5'((r + 1) % 32), 0, 0, 0, 0, 0, 0);
        end

        step(1, 0, 0, 0, 5, 1, 0, 0, 0);
        repeat (3) step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 5, 0, 2'b01, 0, 0, 1, 5, 32'hDEAD_BEEF);
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        idle();

        step(1, 0, 0, 0, 7, 1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 7, 1, 0, 0, 0);
        repeat (4) step(1, 0, 0, 2'b11, 0, 1, 0, 0, 0);
        step(0, 7, 0, 0, 0, 0, 1, 7, 32'h0000_0777);
        step(0, 7, 0, 0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 12, 32'h0000_0012);
        step(0, 12, 0, 0, 0, 0, 1, 0, 32'h5555_5555);
        idle();

        step(1, 0, 0, 0, 9, 1, 1, 9, 32'h0000_0009);
        step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
        step(0, 9, 0, 0, 0, 0, 1, 9, 32'h0000_0099);
        step(0, 9, 0, 0, 0, 0, 0, 0, 0);

        set_rst(1'b0);
        set_rst(1'b1);
        repeat (1500) rand_step();
        repeat (8) step(0, 0, 0, 0, 0, 0, 1, 5'($urandom_range(1, 7)), $urandom);

        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 32'hCAFE_0003);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        repeat (70000) step(1, 3, 3, 2'b11, 0, 0, 0, 0, 0);
        set_rst(1'b0);
        step(1, 3, 3, 2'b11, 0, 0, 0, 0, 0);
        set_rst(1'b1);
        step(1, 3, 5, 2'b11, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 32'h0000_0333);
        step(0, 3, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        nchecks++;
        if (exp_q.size() != 0) begin
            nerrs++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
